// File: rtl/core_pkg.sv
// Shared definitions for the RV32 core slice.
// Holds the data width, register count, the ABI indices used by the
// ecall service (a0/a1/a2), the ecall function codes and the ecall FSM
// state type.
package core_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;

  // ABI register indices consulted by the ecall service
  localparam int A0_IDX = 10;  // function selector
  localparam int A1_IDX = 11;  // sub-code
  localparam int A2_IDX = 12;  // print payload

  // ecall codes: a0 selects the system function, a1 the sub-function
  localparam int ECALL_FN_SYS = 0;
  localparam int ECALL_PRINT  = 1;
  localparam int ECALL_EXIT   = 0;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRINT_WAIT = 2'd1,
    ST_HALTED     = 2'd2
  } ecall_state_e;

endpackage

// File: rtl/regfile_bypass_mux.sv
// Read-port selector for the multi-port register file.
// Returns the same-cycle write data of the highest-numbered committing
// write port that targets rs_idx (when BYPASS is set), otherwise the
// stored value; index 0 always reads zero.
// Ports:
//   rs_idx   in   AW        read index
//   stored   in   XLEN      current array content at rs_idx
//   wr_ok    in   NWR       per-port "this write will commit at the edge"
//   wb_idx   in   NWR*AW    per-port write index
//   wb_data  in   NWR*XLEN  per-port write data
//   rs_data  out  XLEN      selected read data
module regfile_bypass_mux #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]       rs_idx,
  input  logic [XLEN-1:0]     stored,
  input  logic [NWR-1:0]      wr_ok,
  input  logic [NWR*AW-1:0]   wb_idx,
  input  logic [NWR*XLEN-1:0] wb_data,
  output logic [XLEN-1:0]     rs_data
);

  always_comb begin
    rs_data = stored;
    if (BYPASS != 0) begin
      // Ascending scan: a later (higher) matching port overrides earlier ones.
      for (int p = 0; p < NWR; p++) begin
        if (wr_ok[p] && (wb_idx[p*AW +: AW] == rs_idx)) begin
          rs_data = wb_data[p*XLEN +: XLEN];
        end
      end
    end
    if (rs_idx == '0) begin
      rs_data = '0;
    end
  end

endmodule

// File: rtl/regfile_mp_sys.sv
// Multi-port integer register file with ecall print/halt service.
// NRD combinational read ports, NWR posedge write ports, optional
// same-cycle write->read bypass, and a small FSM that serves ecall
// print requests through a valid/ready handshake and a sticky halt.
// Ports:
//   clk          in   1         core clock, rising edge
//   rst          in   1         synchronous active-low reset
//   wb_en        in   NWR       per-port write enable
//   wb_idx       in   NWR*AW    per-port write index, port p at [p*AW +: AW]
//   wb_data      in   NWR*XLEN  per-port write data
//   rs_idx       in   NRD*AW    per-port read index
//   rs_data      out  NRD*XLEN  per-port read data, combinational
//   ecall_sig    in   1         ecall at service point, 1-cycle pulse
//   print_valid  out  1         print request to host
//   print_data   out  XLEN      payload (a2 captured at ecall)
//   print_ready  in   1         host accepts print
//   stall        out  1         pipeline freeze (print pending or halted)
//   halt         out  1         sticky program-end flag
// Handshake: a print transfers at a rising edge where print_valid and
// print_ready are both 1; print_valid/print_data hold steady until then,
// and print_valid never depends combinationally on print_ready.
module regfile_mp_sys #(
  parameter int XLEN   = core_pkg::XLEN,
  parameter int NREGS  = core_pkg::NREGS,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  parameter int A0_IDX = core_pkg::A0_IDX,
  parameter int A1_IDX = core_pkg::A1_IDX,
  parameter int A2_IDX = core_pkg::A2_IDX,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      wb_en,
  input  logic [NWR*AW-1:0]   wb_idx,
  input  logic [NWR*XLEN-1:0] wb_data,
  input  logic [NRD*AW-1:0]   rs_idx,
  output logic [NRD*XLEN-1:0] rs_data,
  input  logic                ecall_sig,
  output logic                print_valid,
  output logic [XLEN-1:0]     print_data,
  input  logic                print_ready,
  output logic                stall,
  output logic                halt
);

  import core_pkg::*;

  localparam logic [AW-1:0] A0_SEL = AW'(A0_IDX);
  localparam logic [AW-1:0] A1_SEL = AW'(A1_IDX);
  localparam logic [AW-1:0] A2_SEL = AW'(A2_IDX);

  logic [XLEN-1:0] regs [NREGS];
  ecall_state_e    state;
  logic [NWR-1:0]  wr_ok;

  // A write commits only outside reset and halt and never to x0. The
  // bypass uses the same qualifier so a bypassed read always matches
  // what the array will hold after the edge.
  always_comb begin
    wr_ok = '0;
    for (int p = 0; p < NWR; p++) begin
      wr_ok[p] = rst && (state != ST_HALTED) && wb_en[p] &&
                 (wb_idx[p*AW +: AW] != '0);
    end
  end

  // Storage; on an index conflict the highest port is applied last and wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_ok[p]) begin
          regs[wb_idx[p*AW +: AW]] <= wb_data[p*XLEN +: XLEN];
        end
      end
    end
  end

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    regfile_bypass_mux #(
      .XLEN   (XLEN),
      .AW     (AW),
      .NWR    (NWR),
      .BYPASS (BYPASS)
    ) u_mux (
      .rs_idx  (rs_idx[r*AW +: AW]),
      .stored  (regs[rs_idx[r*AW +: AW]]),
      .wr_ok   (wr_ok),
      .wb_idx  (wb_idx),
      .wb_data (wb_data),
      .rs_data (rs_data[r*XLEN +: XLEN])
    );
  end

  // Ecall decode looks at the stored (pre-edge) a0/a1/a2, never bypassed data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      print_valid <= 1'b0;
      print_data  <= '0;
      halt        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ecall_sig && (regs[A0_SEL] == XLEN'(ECALL_FN_SYS))) begin
            if (regs[A1_SEL] == XLEN'(ECALL_PRINT)) begin
              state       <= ST_PRINT_WAIT;
              print_valid <= 1'b1;
              print_data  <= regs[A2_SEL];
            end else if (regs[A1_SEL] == XLEN'(ECALL_EXIT)) begin
              state <= ST_HALTED;
              halt  <= 1'b1;
            end
          end
        end
        ST_PRINT_WAIT: begin
          if (print_ready) begin
            state       <= ST_IDLE;
            print_valid <= 1'b0;
          end
        end
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign stall = (state == ST_PRINT_WAIT) || (state == ST_HALTED);

  // Upstream is frozen during a pending print, so a new ecall there is a bug.
  a_no_ecall_in_print: assert property (
    @(posedge clk) disable iff (!rst) !(ecall_sig && (state == ST_PRINT_WAIT))
  );

endmodule

// File: tb/tb_regfile_mp_sys.sv
module tb_regfile_mp_sys;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int EW    = 5*XLEN + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NWR-1:0]      wb_en = '0;
  logic [NWR*AW-1:0]   wb_idx = '0;
  logic [NWR*XLEN-1:0] wb_data = '0;
  logic [NRD*AW-1:0]   rs_idx = '0;
  logic                ecall_sig = 1'b0;
  logic                print_ready = 1'b0;

  logic [NRD*XLEN-1:0] rs_data, rs_data_nb;
  logic                print_valid, stall, halt;
  logic [XLEN-1:0]     print_data;
  logic                print_valid_nb, stall_nb, halt_nb;
  logic [XLEN-1:0]     print_data_nb;

  regfile_mp_sys #(.NRD(NRD), .NWR(NWR), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
    .rs_idx(rs_idx), .rs_data(rs_data), .ecall_sig(ecall_sig),
    .print_valid(print_valid), .print_data(print_data),
    .print_ready(print_ready), .stall(stall), .halt(halt)
  );

  regfile_mp_sys #(.NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
    .rs_idx(rs_idx), .rs_data(rs_data_nb), .ecall_sig(ecall_sig),
    .print_valid(print_valid_nb), .print_data(print_data_nb),
    .print_ready(print_ready), .stall(stall_nb), .halt(halt_nb)
  );

  // ---------------- reference model ----------------
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_printing = 1'b0;
  bit              m_halted = 1'b0;
  logic [XLEN-1:0] m_pdata = '0;

  logic [EW-1:0]   exp_q[$];
  logic [XLEN-1:0] print_q[$];
  int cmp_count = 0;
  int fail_count = 0;

  initial foreach (m_regs[i]) m_regs[i] = '0;

  function automatic logic [XLEN-1:0] ref_read(int r, bit bypass);
    int idx;
    idx = int'(rs_idx[r*AW +: AW]);
    if (idx == 0) return '0;
    if (bypass && rst && !m_halted) begin
      for (int p = NWR-1; p >= 0; p--) begin
        if (wb_en[p] && int'(wb_idx[p*AW +: AW]) == idx) return wb_data[p*XLEN +: XLEN];
      end
    end
    return m_regs[idx];
  endfunction

  task automatic model_edge();
    logic [XLEN-1:0] a0, a1, a2;
    bit was_halted;
    if (!rst) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_printing = 0;
      m_halted = 0;
      m_pdata = '0;
      print_q.delete();
      return;
    end
    a0 = m_regs[10];
    a1 = m_regs[11];
    a2 = m_regs[12];
    was_halted = m_halted;
    if (m_printing) begin
      if (print_ready) m_printing = 0;
    end else if (!m_halted && ecall_sig && a0 == 0) begin
      if (a1 == 1) begin
        m_printing = 1;
        m_pdata = a2;
        print_q.push_back(a2);
      end else if (a1 == 0) begin
        m_halted = 1;
      end
    end
    if (!was_halted) begin
      for (int p = 0; p < NWR; p++) begin
        if (wb_en[p] && wb_idx[p*AW +: AW] != 0)
          m_regs[wb_idx[p*AW +: AW]] = wb_data[p*XLEN +: XLEN];
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clr();
    wb_en = '0;
    wb_idx = '0;
    wb_data = '0;
    ecall_sig = 1'b0;
  endtask

  task automatic wr(input int p, input int idx, input logic [XLEN-1:0] d);
    wb_en[p] = 1'b1;
    wb_idx[p*AW +: AW] = AW'(idx);
    wb_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic rd(input int i0, input int i1);
    rs_idx = {AW'(i1), AW'(i0)};
  endtask

  // One cycle: record expectation for the current inputs, then clock the model.
  task automatic step();
    logic [EW-1:0] e;
    e = {ref_read(0, 1), ref_read(1, 1), ref_read(0, 0), ref_read(1, 0),
         m_pdata, m_printing, (m_printing || m_halted), m_halted};
    exp_q.push_back(e);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  function automatic void check(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
    cmp_count++;
    if (act !== exp) begin
      fail_count++;
      $display("FAIL %s at %0t: got 0x%h, expected 0x%h", name, $time, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rd0_bypass",  rs_data[0 +: XLEN],       e[EW-1 -: XLEN]);
      check("rd1_bypass",  rs_data[XLEN +: XLEN],    e[EW-33 -: XLEN]);
      check("rd0_stored",  rs_data_nb[0 +: XLEN],    e[EW-65 -: XLEN]);
      check("rd1_stored",  rs_data_nb[XLEN +: XLEN], e[EW-97 -: XLEN]);
      check("print_data",  print_data,               e[EW-129 -: XLEN]);
      check("print_valid", XLEN'(print_valid),       XLEN'(e[2]));
      check("stall",       XLEN'(stall),             XLEN'(e[1]));
      check("halt",        XLEN'(halt),              XLEN'(e[0]));
    end
    if (print_valid && print_ready) begin
      if (print_q.size() == 0) begin
        cmp_count++;
        fail_count++;
        $display("FAIL print_xfer at %0t: got unexpected print 0x%h, expected none", $time, print_data);
      end else begin
        check("print_xfer", print_data, print_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset held for two cycles while a write to x5 is attempted.
    clr();
    rst = 1'b0;
    wr(0, 5, 32'hDEAD);
    rd(5, 5);
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b1;
    clr();
    step();

    // Write/read and x0.
    wr(0, 5, 32'h1234);
    rd(5, 0);
    step();
    clr();
    step();
    wr(0, 0, 32'hFFFF_FFFF);
    rd(0, 5);
    step();
    clr();
    step();

    // Same-index conflict on x7 with bypass and stored read views.
    wr(0, 7, 32'hAAAA);
    wr(1, 7, 32'h5555);
    rd(7, 7);
    step();
    clr();
    step();

    // Print handshake: a1=1, a2=42, ecall, three cycles of backpressure.
    wr(0, 11, 32'd1);
    wr(1, 12, 32'd42);
    rd(10, 12);
    step();
    clr();
    ecall_sig = 1'b1;
    step();
    ecall_sig = 1'b0;
    repeat (3) step();
    print_ready = 1'b1;
    step();
    print_ready = 1'b0;
    step();

    // Halt, then ignored write and ignored ecall.
    wr(0, 11, 32'd0);
    step();
    clr();
    ecall_sig = 1'b1;
    step();
    ecall_sig = 1'b0;
    wr(0, 3, 32'd9);
    rd(3, 11);
    step();
    clr();
    step();
    wr(0, 10, 32'd5);
    step();
    clr();
    ecall_sig = 1'b1;
    step();
    ecall_sig = 1'b0;
    repeat (2) step();

    // Reset in the middle of a pending print.
    rst = 1'b0;
    step();
    rst = 1'b1;
    wr(0, 11, 32'd1);
    wr(1, 12, 32'd77);
    rd(12, 11);
    step();
    clr();
    ecall_sig = 1'b1;
    step();
    ecall_sig = 1'b0;
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();

    // Randomized traffic biased towards the ecall registers.
    for (int n = 0; n < 3000; n++) begin
      int idx;
      rst = ($urandom_range(0, m_halted ? 8 : 300) != 0);
      for (int p = 0; p < NWR; p++) begin
        wb_en[p] = 1'($urandom_range(0, 1));
        idx = ($urandom_range(0, 3) == 0) ? 10 + int'($urandom_range(0, 2)) : int'($urandom_range(0, 31));
        wb_idx[p*AW +: AW] = AW'(idx);
        wb_data[p*XLEN +: XLEN] = (idx == 10 || idx == 11) ? XLEN'($urandom_range(0, 2)) : XLEN'($urandom);
      end
      for (int r = 0; r < NRD; r++) begin
        rs_idx[r*AW +: AW] = ($urandom_range(0, 2) == 0) ?
          wb_idx[$urandom_range(0, NWR-1)*AW +: AW] : AW'($urandom_range(0, 31));
      end
      ecall_sig = !m_printing && ($urandom_range(0, 5) == 0);
      print_ready = 1'($urandom_range(0, 1));
      step();
    end

    // Drain any pending print.
    clr();
    rst = 1'b1;
    print_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    #1;
    cmp_count++;
    if (print_q.size() != 0 || exp_q.size() != 0) begin
      fail_count++;
      $display("FAIL drain: got %0d prints / %0d cycles outstanding, expected 0 / 0",
               print_q.size(), exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
